dmem_bridge: RTL and testbench

Memory-stage data-memory port for the pipelined ARM core. Takes the M-stage access (address, store data, write strobe, byte/word size) from the datapath, runs a req/ack transaction on the external data-memory bus, and returns lane-aligned load data as ReadDataM. It holds the whole pipeline with StallMem until the transaction completes. A bus timeout ends any hung transaction and raises an error.

---
 rtl/dmem_pkg.sv | 17 +
 rtl/dmem_lane_steer.sv | 29 ++
 rtl/dmem_bridge.sv | 132 +++++++++++++
 tb/tb_dmem_bridge.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// Shared types and constants for the M-stage data-memory bridge.
package dmem_pkg;

  typedef enum logic [1:0] {IDLE, BUS, DONE} dmem_state_t;

  localparam int unsigned DEFAULT_TIMEOUT = 16;

  localparam logic [3:0] BE_WORD  = 4'b1111;
  localparam logic [3:0] BE_BYTE0 = 4'b0001;

  // Attributes of the access latched at issue time.
  typedef struct packed {
    logic we;
    logic byte_sz;
  } dmem_attr_t;

endpackage

// File: rtl/dmem_lane_steer.sv
// Byte-lane steering: store strobes/replication and load extraction/zero-extend.
module dmem_lane_steer
  import dmem_pkg::*;
(
  input  logic        byte_i,
  input  logic [1:0]  lane_i,
  input  logic [31:0] wdata_i,
  input  logic [31:0] rdata_i,
  output logic [3:0]  be_o,
  output logic [31:0] wdata_o,
  output logic [31:0] rdata_o
);

  logic [7:0] rbyte;

  always_comb begin
    case (lane_i)
      2'd0:    rbyte = rdata_i[7:0];
      2'd1:    rbyte = rdata_i[15:8];
      2'd2:    rbyte = rdata_i[23:16];
      default: rbyte = rdata_i[31:24];
    endcase
  end

  assign be_o    = byte_i ? 4'(BE_BYTE0 << lane_i) : BE_WORD;
  assign wdata_o = byte_i ? {4{wdata_i[7:0]}} : wdata_i;
  assign rdata_o = byte_i ? {24'b0, rbyte} : rdata_i;

endmodule

// File: rtl/dmem_bridge.sv
// M-stage data-memory port: req/ack bus transaction, pipeline stall, timeout and alignment errors.
module dmem_bridge
  import dmem_pkg::*;
#(
  parameter int unsigned TIMEOUT = DEFAULT_TIMEOUT,
  parameter int unsigned AW      = 32
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          MemReadM,
  input  logic          MemWriteM,
  input  logic          ByteM,
  input  logic [AW-1:0] ALUResultM,
  input  logic [31:0]   WriteDataM,
  output logic [31:0]   ReadDataM,
  output logic          StallMem,
  output logic          bus_req,
  output logic          bus_we,
  output logic [AW-1:0] bus_addr,
  output logic [3:0]    bus_be,
  output logic [31:0]   bus_wdata,
  input  logic          bus_ack,
  input  logic [31:0]   bus_rdata,
  output logic          BusErr,
  output logic          AlignErr
);

  localparam int unsigned CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

  dmem_state_t   state_q, state_d;
  dmem_attr_t    attr_q, attr_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [31:0]   wdata_q, wdata_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [31:0]   rdata_q, rdata_d;
  logic          bus_err_q, bus_err_d;
  logic          align_err_q, align_err_d;
  logic          stall_c;

  logic [3:0]    steer_be;
  logic [31:0]   steer_wdata;
  logic [31:0]   steer_rdata;

  dmem_lane_steer u_steer (
    .byte_i  (attr_q.byte_sz),
    .lane_i  (addr_q[1:0]),
    .wdata_i (wdata_q),
    .rdata_i (bus_rdata),
    .be_o    (steer_be),
    .wdata_o (steer_wdata),
    .rdata_o (steer_rdata)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      attr_q      <= '0;
      addr_q      <= '0;
      wdata_q     <= '0;
      cnt_q       <= '0;
      rdata_q     <= '0;
      bus_err_q   <= 1'b0;
      align_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      attr_q      <= attr_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      cnt_q       <= cnt_d;
      rdata_q     <= rdata_d;
      bus_err_q   <= bus_err_d;
      align_err_q <= align_err_d;
    end
  end

  // Next-state: DONE is a single non-stalling cycle that never issues an access.
  always_comb begin
    state_d     = state_q;
    attr_d      = attr_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    cnt_d       = '0;
    rdata_d     = rdata_q;
    bus_err_d   = bus_err_q;
    align_err_d = align_err_q;
    stall_c     = 1'b0;
    case (state_q)
      IDLE: begin
        if (MemReadM || MemWriteM) begin
          stall_c = 1'b1;
          if (!ByteM && (ALUResultM[1:0] != 2'b00)) begin
            align_err_d = 1'b1;
            rdata_d     = '0;
            state_d     = DONE;
          end else begin
            attr_d.we      = MemWriteM;
            attr_d.byte_sz = ByteM;
            addr_d         = ALUResultM;
            wdata_d        = WriteDataM;
            state_d        = BUS;
          end
        end
      end
      BUS: begin
        stall_c = 1'b1;
        if (bus_ack) begin
          rdata_d = attr_q.we ? 32'h0 : steer_rdata;
          state_d = DONE;
        end else if (cnt_q == CW'(TIMEOUT - 1)) begin
          bus_err_d = 1'b1;
          rdata_d   = '0;
          state_d   = DONE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign StallMem  = stall_c;
  assign ReadDataM = rdata_q;
  assign bus_req   = (state_q == BUS);
  assign bus_we    = bus_req & attr_q.we;
  assign bus_be    = bus_req ? steer_be : 4'b0000;
  assign bus_addr  = {addr_q[AW-1:2], 2'b00};
  assign bus_wdata = steer_wdata;
  assign BusErr    = bus_err_q;
  assign AlignErr  = align_err_q;

endmodule

// File: tb/tb_dmem_bridge.sv
// Directed bench for dmem_bridge: table of accesses plus reset/ack corner sequences.
module tb_dmem_bridge;

  logic        clk = 1'b0;
  logic        reset;
  logic        MemReadM, MemWriteM, ByteM;
  logic [31:0] ALUResultM, WriteDataM;
  logic [31:0] ReadDataM;
  logic        StallMem;
  logic        bus_req, bus_we;
  logic [31:0] bus_addr;
  logic [3:0]  bus_be;
  logic [31:0] bus_wdata;
  logic        bus_ack;
  logic [31:0] bus_rdata;
  logic        BusErr, AlignErr;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  dmem_bridge #(.TIMEOUT(4), .AW(32)) dut (
    .clk        (clk),
    .reset      (reset),
    .MemReadM   (MemReadM),
    .MemWriteM  (MemWriteM),
    .ByteM      (ByteM),
    .ALUResultM (ALUResultM),
    .WriteDataM (WriteDataM),
    .ReadDataM  (ReadDataM),
    .StallMem   (StallMem),
    .bus_req    (bus_req),
    .bus_we     (bus_we),
    .bus_addr   (bus_addr),
    .bus_be     (bus_be),
    .bus_wdata  (bus_wdata),
    .bus_ack    (bus_ack),
    .bus_rdata  (bus_rdata),
    .BusErr     (BusErr),
    .AlignErr   (AlignErr)
  );

  typedef struct {
    logic        rd, wr, by;
    logic [31:0] addr, wdata, rdata;
    int          ack_at;     // BUS cycle (1-based) that acks; 0 = never
    int          exp_stall, exp_req;
    logic [3:0]  exp_be;
    logic [31:0] exp_addr, exp_wdata, exp_rd;
    logic        exp_we, exp_berr, exp_aerr;
  } vec_t;

  vec_t vecs[10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    int          stall = 0;
    int          req   = 0;
    int          unstable = 0;
    bit          done  = 0;
    logic [3:0]  be0;
    logic [31:0] addr0, wdata0;
    logic        we0;
    @(negedge clk);
    MemReadM   = v.rd;
    MemWriteM  = v.wr;
    ByteM      = v.by;
    ALUResultM = v.addr;
    WriteDataM = v.wdata;
    for (int c = 0; c < 50 && !done; c++) begin
      if (c > 0) @(negedge clk);
      bus_ack = 1'b0;
      if (bus_req === 1'b1) begin
        req++;
        if (req == 1) begin
          be0 = bus_be; addr0 = bus_addr; wdata0 = bus_wdata; we0 = bus_we;
        end else if (bus_be !== be0 || bus_addr !== addr0 || bus_wdata !== wdata0 || bus_we !== we0) begin
          unstable++;
        end
        if (req == v.ack_at) begin
          bus_ack   = 1'b1;
          bus_rdata = v.rdata;
        end
      end
      #1;
      if (StallMem === 1'b1) stall++;
      else begin
        done = 1;
        check($sformatf("v%0d rdata", idx), ReadDataM, v.exp_rd);
        check($sformatf("v%0d buserr", idx), 32'(BusErr), 32'(v.exp_berr));
        check($sformatf("v%0d alignerr", idx), 32'(AlignErr), 32'(v.exp_aerr));
      end
    end
    if (!done) check($sformatf("v%0d completion", idx), 32'(0), 32'(1));
    MemReadM  = 1'b0;
    MemWriteM = 1'b0;
    bus_ack   = 1'b0;
    check($sformatf("v%0d stall_cycles", idx), 32'(stall), 32'(v.exp_stall));
    check($sformatf("v%0d req_cycles", idx), 32'(req), 32'(v.exp_req));
    if (req > 0) begin
      check($sformatf("v%0d be", idx), 32'(be0), 32'(v.exp_be));
      check($sformatf("v%0d addr", idx), addr0, v.exp_addr);
      check($sformatf("v%0d wdata", idx), wdata0, v.exp_wdata);
      check($sformatf("v%0d we", idx), 32'(we0), 32'(v.exp_we));
      check($sformatf("v%0d bus_stable", idx), 32'(unstable), 32'(0));
    end
  endtask

  initial begin
    int   req_seen;
    vec_t extra;
    //          rd   wr   by   addr        wdata         rdata         ack st rq be     exp_addr    exp_wdata     exp_rd        we   berr aerr
    vecs[0] = '{1'b1,1'b0,1'b0,32'h100,   32'h0,        32'hDEADBEEF, 3, 4, 3, 4'hF,  32'h100,   32'h0,        32'hDEADBEEF, 1'b0,1'b0,1'b0};
    vecs[1] = '{1'b0,1'b1,1'b1,32'h203,   32'h12345678, 32'hFFFFFFFF, 1, 2, 1, 4'h8,  32'h200,   32'h78787878, 32'h0,        1'b1,1'b0,1'b0};
    vecs[2] = '{1'b1,1'b0,1'b1,32'h302,   32'h11223344, 32'hAABBCCDD, 2, 3, 2, 4'h4,  32'h300,   32'h44444444, 32'h000000BB, 1'b0,1'b0,1'b0};
    vecs[3] = '{1'b0,1'b1,1'b0,32'h404,   32'hCAFEF00D, 32'h12121212, 1, 2, 1, 4'hF,  32'h404,   32'hCAFEF00D, 32'h0,        1'b1,1'b0,1'b0};
    vecs[4] = '{1'b1,1'b0,1'b1,32'h001,   32'h0,        32'h11223344, 4, 5, 4, 4'h2,  32'h000,   32'h0,        32'h00000033, 1'b0,1'b0,1'b0};
    vecs[5] = '{1'b1,1'b0,1'b1,32'h000,   32'h0,        32'h11223344, 1, 2, 1, 4'h1,  32'h000,   32'h0,        32'h00000044, 1'b0,1'b0,1'b0};
    vecs[6] = '{1'b1,1'b0,1'b0,32'h500,   32'h0,        32'h0,        0, 5, 4, 4'hF,  32'h500,   32'h0,        32'h0,        1'b0,1'b1,1'b0};
    vecs[7] = '{1'b1,1'b0,1'b1,32'h302,   32'h0,        32'hA1B2C3D4, 1, 2, 1, 4'h4,  32'h300,   32'h0,        32'h000000B2, 1'b0,1'b1,1'b0};
    vecs[8] = '{1'b1,1'b0,1'b0,32'h101,   32'h0,        32'h0,        1, 1, 0, 4'h0,  32'h0,     32'h0,        32'h0,        1'b0,1'b1,1'b1};
    vecs[9] = '{1'b0,1'b1,1'b0,32'h206,   32'h55,       32'h0,        1, 1, 0, 4'h0,  32'h0,     32'h0,        32'h0,        1'b0,1'b1,1'b1};

    reset = 1'b0; MemReadM = 1'b0; MemWriteM = 1'b0; ByteM = 1'b0;
    ALUResultM = '0; WriteDataM = '0; bus_ack = 1'b0; bus_rdata = '0;
    repeat (2) @(negedge clk);
    check("rst bus_req", 32'(bus_req), 32'(0));
    check("rst stall", 32'(StallMem), 32'(0));
    check("rst rdata", ReadDataM, 32'h0);
    check("rst errs", 32'({BusErr, AlignErr}), 32'(0));
    check("rst bus_addr", bus_addr, 32'h0);
    reset = 1'b1;

    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      run_vec(vecs[i], i);
    end

    // Word load, then an ack while idle must not disturb the held load data.
    extra = '{1'b1,1'b0,1'b0,32'h700,32'h0,32'h0BADF00D,2,3,2,4'hF,32'h700,32'h0,32'h0BADF00D,1'b0,1'b1,1'b1};
    run_vec(extra, 10);
    @(negedge clk);
    bus_ack = 1'b1; bus_rdata = 32'hFFFFFFFF;
    #1;
    check("idle_ack stall", 32'(StallMem), 32'(0));
    check("idle_ack bus_req", 32'(bus_req), 32'(0));
    @(negedge clk);
    bus_ack = 1'b0;
    check("idle_ack hold", ReadDataM, 32'h0BADF00D);
    check("idle_ack bus_req2", 32'(bus_req), 32'(0));

    // Reset asserted while BUS is active.
    @(negedge clk);
    MemReadM = 1'b1; ByteM = 1'b0; ALUResultM = 32'h600;
    @(negedge clk);
    check("pre_rst bus_req", 32'(bus_req), 32'(1));
    #2;
    reset = 1'b0; MemReadM = 1'b0;
    #1;
    check("mid_rst bus_req", 32'(bus_req), 32'(0));
    check("mid_rst stall", 32'(StallMem), 32'(0));
    check("mid_rst be_we", 32'({bus_be, bus_we}), 32'(0));
    check("mid_rst addr", bus_addr, 32'h0);
    check("mid_rst wdata", bus_wdata, 32'h0);
    check("mid_rst rdata", ReadDataM, 32'h0);
    check("mid_rst errs", 32'({BusErr, AlignErr}), 32'(0));
    @(negedge clk);
    reset = 1'b1;
    req_seen = 0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      #1;
      if (bus_req !== 1'b0 || StallMem !== 1'b0) req_seen++;
    end
    check("post_rst no_reissue", 32'(req_seen), 32'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
